// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: start/stop, one-shot or periodic timer around a wrap-around counter (ports: CLK, ASYNCRESET, start handshake, cfg_*, stop -> O, COUT, busy, done, wrap_cnt)
module interval_timer_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      CLK,
  input  logic                      ASYNCRESET,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [WIDTH-1:0]          cfg_period,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
  input  logic                      cfg_oneshot,
  input  logic                      stop,
  output logic [WIDTH-1:0]          O,
  output logic                      COUT,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                wrap_cnt
);
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
  state_t                    r_state;
  logic [WIDTH-1:0]          r_period;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] r_presc_cnt;
  logic                      r_oneshot;
  logic                      w_tick;
  logic                      w_wrap;
  assign w_tick      = r_presc_cnt == r_prescale;
  assign w_wrap      = w_tick && O == r_period;
  assign start_ready = r_state == IDLE && !ASYNCRESET;
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_state     <= IDLE;
      r_period    <= '0;
      r_prescale  <= '0;
      r_presc_cnt <= '0;
      r_oneshot   <= 1'b0;
      O           <= '0;
      COUT        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wrap_cnt    <= '0;
    end else begin
      COUT <= 1'b0;
      done <= 1'b0;
      case (r_state)
        IDLE: if (start_valid) begin
          r_period   <= cfg_period;
          r_prescale <= cfg_prescale;
          r_oneshot  <= cfg_oneshot;
          r_state    <= ARM;
          busy       <= 1'b1;
        end
        ARM: begin
          O           <= '0;
          r_presc_cnt <= '0;
          wrap_cnt    <= '0;
          r_state     <= stop ? DONE : RUN;
          busy        <= !stop;
          done        <= stop;
        end
        RUN: if (stop) begin
          r_state <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end else begin
          r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PRESCALE_WIDTH'(1);
          if (w_wrap) begin
            O        <= '0;
            COUT     <= 1'b1;
            wrap_cnt <= (wrap_cnt == 8'hff) ? wrap_cnt : wrap_cnt + 8'd1;
            if (r_oneshot) begin
              r_state <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else if (w_tick) O <= O + WIDTH'(1);
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb_interval_timer_ctrl: table-driven and directed checks of interval_timer_ctrl
module tb_interval_timer_ctrl;
  logic       CLK = 1'b0;
  logic       ASYNCRESET = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [3:0] cfg_period = '0;
  logic [3:0] cfg_prescale = '0;
  logic       cfg_oneshot = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] O;
  logic       COUT;
  logic       busy;
  logic       done;
  logic [7:0] wrap_cnt;
  int         n_vec = 0;
  int         n_err = 0;
  typedef struct {
    logic       sv;
    logic [3:0] per;
    logic [3:0] pre;
    logic       os;
    logic       stp;
    logic [3:0] o;
    logic       c;
    logic       b;
    logic       d;
    logic       r;
    logic [7:0] wc;
  } vec_t;
  vec_t tbl[$];
  interval_timer_ctrl #(.WIDTH(4), .PRESCALE_WIDTH(4)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .start_valid(start_valid), .start_ready(start_ready),
    .cfg_period(cfg_period), .cfg_prescale(cfg_prescale), .cfg_oneshot(cfg_oneshot), .stop(stop),
    .O(O), .COUT(COUT), .busy(busy), .done(done), .wrap_cnt(wrap_cnt)
  );
  always #5 CLK = ~CLK;
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic add(input logic sv, input logic [3:0] per, input logic [3:0] pre, input logic os,
                     input logic stp, input logic [3:0] o, input logic c, input logic b,
                     input logic d, input logic r, input logic [7:0] wc);
    vec_t v;
    v.sv = sv; v.per = per; v.pre = pre; v.os = os; v.stp = stp;
    v.o = o; v.c = c; v.b = b; v.d = d; v.r = r; v.wc = wc;
    tbl.push_back(v);
  endtask
  task automatic start(input logic [3:0] per, input logic [3:0] pre, input logic os);
    cfg_period = per; cfg_prescale = pre; cfg_oneshot = os; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
  endtask
  initial begin
    // one-shot, period 3, prescale 0
    add(1, 3, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 3, 0, 1, 0, 4'(i), 0, 1, 0, 0, 0);
    add(0, 3, 0, 1, 0, 0, 1, 0, 1, 0, 1);
    add(0, 3, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    // periodic, period 2, prescale 1, then stop
    add(1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 13; i++)
      add(0, 2, 1, 0, 0, 4'((i % 6) / 2), logic'(i > 0 && i % 6 == 0), 1, 0, 0, 8'(i / 6));
    add(0, 2, 1, 0, 1, 0, 0, 0, 1, 0, 2);
    add(0, 2, 1, 0, 0, 0, 0, 0, 0, 1, 2);
    // stop colliding with a wrap, period 1, prescale 0
    add(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1);
    add(0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1);
    add(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    #1;
    chk("rst_O", O, 0); chk("rst_COUT", COUT, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_ready", start_ready, 0); chk("rst_wc", wrap_cnt, 0);
    step();
    ASYNCRESET = 1'b0;
    step();
    chk("idle_ready", start_ready, 1);
    foreach (tbl[i]) begin
      start_valid = tbl[i].sv; cfg_period = tbl[i].per; cfg_prescale = tbl[i].pre;
      cfg_oneshot = tbl[i].os; stop = tbl[i].stp;
      step();
      chk($sformatf("v%0d_O", i), O, tbl[i].o);
      chk($sformatf("v%0d_COUT", i), COUT, tbl[i].c);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].b);
      chk($sformatf("v%0d_done", i), done, tbl[i].d);
      chk($sformatf("v%0d_ready", i), start_ready, tbl[i].r);
      chk($sformatf("v%0d_wc", i), wrap_cnt, tbl[i].wc);
    end
    stop = 1'b0;
    // asynchronous reset mid-run at O=5
    start(9, 0, 0);
    repeat (6) step();
    chk("mid_O5", O, 5);
    ASYNCRESET = 1'b1;
    #1;
    chk("arst_O", O, 0); chk("arst_COUT", COUT, 0); chk("arst_done", done, 0);
    chk("arst_busy", busy, 0); chk("arst_ready", start_ready, 0);
    #1;
    ASYNCRESET = 1'b0;
    step();
    chk("post_rst_ready", start_ready, 1); chk("post_rst_done", done, 0);
    // period 0: wrap on every tick, then saturation
    start(0, 0, 0);
    step();
    chk("p0_idx0_COUT", COUT, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("p0_COUT", COUT, 1); chk("p0_O", O, 0); chk("p0_wc", wrap_cnt, i);
    end
    repeat (300) step();
    chk("sat_wc", wrap_cnt, 255); chk("sat_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("sat_done", done, 1); chk("sat_wc_hold", wrap_cnt, 255);
    step();
    // period 15: full range, wrap after 16 ticks
    start(15, 0, 1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("p15_O%0d", i), O, i);
    end
    step();
    chk("p15_COUT", COUT, 1); chk("p15_done", done, 1); chk("p15_O", O, 0); chk("p15_wc", wrap_cnt, 1);
    step();
    // start_valid held high, cfg changed mid-run, then stop during ARM
    cfg_period = 1; cfg_prescale = 0; cfg_oneshot = 1; start_valid = 1'b1;
    step();
    chk("hs_arm_busy", busy, 1); chk("hs_arm_ready", start_ready, 0);
    cfg_period = 7; cfg_prescale = 3; cfg_oneshot = 0;
    step();
    chk("hs_run0_O", O, 0);
    step();
    chk("hs_run1_O", O, 1);
    step();
    chk("hs_done", done, 1); chk("hs_COUT", COUT, 1); chk("hs_done_ready", start_ready, 0);
    step();
    chk("hs_idle_ready", start_ready, 1); chk("hs_idle_busy", busy, 0);
    step();
    chk("hs_reaccept_busy", busy, 1); chk("hs_reaccept_ready", start_ready, 0);
    start_valid = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;
    chk("armstop_done", done, 1); chk("armstop_COUT", COUT, 0);
    chk("armstop_busy", busy, 0); chk("armstop_wc", wrap_cnt, 0);
    step();
    chk("armstop_idle", start_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/interval_timer_ctrl.md
# interval_timer_ctrl

Programmable interval-timer controller that sequences a WIDTH-bit wrap-around counter with a carry-out pulse, the controlled form of the free-running counter datapath. It accepts a start command over a valid/ready handshake, latches the period, prescale and mode, and then steps the counter once per prescaled tick. The counter wraps at the programmed terminal value, and the block reports wraps and completion. It sits between a host or sequencer and the counter datapath, and turns a free-running counter into a start/stop, one-shot or periodic timer.

## Interface
- WIDTH, 4: counter width; `cfg_period` and `O` are this wide.
- PRESCALE_WIDTH, 4: prescaler width; one tick every `cfg_prescale+1` RUN cycles.
- CLK  in  1  clock; all state updates on rising edge.
- ASYNCRESET  in  1  asynchronous, active-high reset.
- start_valid  in  1  start command valid.
- start_ready  out  1  high only in IDLE with ASYNCRESET low.
- cfg_period  in  WIDTH  terminal count, latched on accept.
- cfg_prescale  in  PRESCALE_WIDTH  tick divider, latched on accept.
- cfg_oneshot  in  1  1 = stop after first wrap; 0 = periodic. Latched on accept.
- stop  in  1  abort request; sampled in ARM and RUN only.
- O  out  WIDTH  current count, registered.
- COUT  out  1  registered one-cycle wrap pulse.
- busy  out  1  high in ARM and RUN.
- done  out  1  registered one-cycle completion pulse.
- wrap_cnt  out  8  wraps since last start, saturating at 255.

## Operation
- States: IDLE, ARM, RUN, DONE. Encoded in a registered state register.
- IDLE:
  - start_ready=1.
  - Accept when start_valid && start_ready; latch cfg_*; go to ARM.
- ARM (1 cycle):
  - O<=0, prescaler<=0, wrap_cnt<=0.
  - stop=1 -> DONE; else -> RUN.
- RUN:
  - Each cycle: tick = (prescaler == latched prescale). prescaler<=0 on tick, else prescaler+1.
  - On tick with O != period: O<=O+1, no COUT.
  - On tick with O == period (wrap):
    - O<=0, COUT<=1, wrap_cnt<=sat(wrap_cnt+1).
    - One-shot: -> DONE. Periodic: stay in RUN.
  - stop=1: -> DONE. Stop has priority over a same-cycle tick or wrap: O holds, no COUT, no wrap_cnt increment.
- DONE (1 cycle): done=1; O and wrap_cnt hold; -> IDLE.
- O holds its final value in IDLE until the next ARM. Readback after stop is valid.
- Arithmetic:
  - O increment is modulo 2^WIDTH. It never exceeds period, because the wrap compare happens first.
  - period=0: O stays 0; COUT on every tick.
  - period=2^WIDTH-1: O wraps through the full range.
- Config input changes after accept have no effect until the next accept.
- start_valid outside IDLE is ignored. It is not queued.

## Timing
- Reset (async assert, any state):
  - state=IDLE, O=0, COUT=0, done=0, busy=0, wrap_cnt=0, prescaler=0, latched config=0.
  - start_ready=0 while ASYNCRESET high; 1 from the first cycle after deassert.
- Accept at edge k: ARM during cycle k+1 (busy=1, start_ready=0); RUN from cycle k+2.
- With prescale=p:
  - First tick is in RUN cycle index p (0-based).
  - O=1 first visible in RUN cycle p+1.
  - Subsequent increments every p+1 cycles.
- COUT is high for exactly the one cycle in which O first shows 0 after a wrap.
- One-shot: COUT and done high in the same cycle (the DONE cycle); start_ready=1 the following cycle.
- Stop:
  - Stop asserted in RUN cycle n: DONE in cycle n+1, IDLE in cycle n+2.
  - Minimum turnaround from accept to next accept is 3 cycles (accept, ARM+stop, DONE).
- Reset mid-RUN: outputs clear immediately (asynchronous); no done pulse is generated.
- busy, COUT and done are glitch-free registered outputs. start_ready is decoded from state and gated by reset.

## Test plan
- Reset then idle: assert ASYNCRESET mid-RUN at O=5 -> O=0, COUT=0, done=0, busy=0 immediately; start_ready=1 one cycle after deassert.
- One-shot, period=3, prescale=0: accept at edge k -> O sequence 0,1,2,3 in cycles k+2..k+5; cycle k+6 O=0, COUT=1, done=1, wrap_cnt=1; cycle k+7 start_ready=1.
- Periodic, period=2, prescale=1 (WIDTH=4): O=0,0,1,1,2,2,0,… from the first RUN cycle; COUT every 6 cycles; wrap_cnt counts 1,2,3; busy stays 1.
- Stop/wrap collision: periodic period=1, prescale=0; assert stop in a cycle with O=1 -> next cycle DONE with done=1, COUT=0, O=1 held, wrap_cnt unchanged.
- Edge values: period=0 gives a COUT every tick with O=0; period=15, WIDTH=4 gives a wrap after 16 ticks; wrap_cnt saturates at 255 after 300 wraps.
- Handshake: start_valid held high throughout a one-shot run -> exactly one accept per IDLE visit; cfg changes during RUN do not alter the period; stop during ARM -> DONE, no COUT.
